// File: rtl/defuzz_pkg.sv
// Shared constants and types for the centroid defuzzifier.
// Q-format parameters, accumulator width, FSM states and saturation limit.
package defuzz_pkg;

   localparam int          FRAC_BITS = 12;
   localparam int          ACC_W     = 40;
   localparam logic [31:0] ONE_Q     = 32'h1000;
   localparam logic [31:0] Q_MAX     = 32'h7FFF_FFFF;

   typedef enum logic [1:0] {
      ACCUM,
      LOAD,
      DIV
   } state_e;

endpackage

// File: rtl/seq_udiv.sv
// Unsigned restoring divider, one quotient bit per cycle, MSB first.
// Ports: start/num/den load an operation; done strobes with quo on the
// final iteration (quo is the completed quotient in that cycle).
module seq_udiv #(
   parameter int N_W = 52,
   parameter int D_W = 40
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [N_W-1:0] num,
   input  logic [D_W-1:0] den,
   output logic           done,
   output logic [N_W-1:0] quo
);

   localparam int C_W = $clog2(N_W + 1);

   logic           busy_q, busy_d;
   logic [C_W-1:0] cnt_q, cnt_d;
   logic [N_W-1:0] num_q, num_d;
   logic [D_W-1:0] den_q, den_d;
   logic [D_W-1:0] rem_q, rem_d;
   logic [N_W-1:0] quo_q, quo_d;

   logic [D_W-1:0] trial_lo;
   logic           fits;
   logic           last;

   // The partial remainder is always below den, so the shifted trial
   // value only needs D_W+1 bits; its top bit is rem_q's MSB.
   assign trial_lo = {rem_q[D_W-2:0], num_q[N_W-1]};
   assign fits     = rem_q[D_W-1] | (trial_lo >= den_q);
   assign last     = (cnt_q == C_W'(N_W - 1));
   assign done     = busy_q & last;
   assign quo      = {quo_q[N_W-2:0], fits};

   always_comb begin
      busy_d = busy_q;
      cnt_d  = cnt_q;
      num_d  = num_q;
      den_d  = den_q;
      rem_d  = rem_q;
      quo_d  = quo_q;
      if (start) begin
         busy_d = 1'b1;
         cnt_d  = '0;
         num_d  = num;
         den_d  = den;
         rem_d  = '0;
         quo_d  = '0;
      end else if (busy_q) begin
         // Subtraction wraps correctly: the true difference is < den.
         rem_d = fits ? (trial_lo - den_q) : trial_lo;
         num_d = num_q << 1;
         quo_d = {quo_q[N_W-2:0], fits};
         cnt_d = cnt_q + C_W'(1);
         if (last) begin
            busy_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
         num_q  <= '0;
         den_q  <= '0;
         rem_q  <= '0;
         quo_q  <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
         num_q  <= num_d;
         den_q  <= den_d;
         rem_q  <= rem_d;
         quo_q  <= quo_d;
      end
   end

endmodule

// File: rtl/centroid_defuzzifier.sv
// Centroid defuzzifier: accumulates NUM_RULES {area, area*center} beats,
// then divides the weighted sum by total area to give one crisp Q value.
// Ports: in_valid/area_in/wsum_in beats (in_ready in ACCUM only);
// crisp_out/crisp_valid result with div_by_zero qualifier; sticky
// drop_err for beats refused while busy; busy during LOAD and DIV.
module centroid_defuzzifier #(
   parameter int NUM_RULES = 9,
   parameter int FRAC_BITS = defuzz_pkg::FRAC_BITS,
   parameter int ACC_W     = defuzz_pkg::ACC_W
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [31:0] area_in,
   input  logic [31:0] wsum_in,
   output logic        in_ready,
   output logic [31:0] crisp_out,
   output logic        crisp_valid,
   output logic        div_by_zero,
   output logic        drop_err,
   output logic        busy
);

   import defuzz_pkg::*;

   localparam int N_W   = ACC_W + FRAC_BITS;
   localparam int CNT_W = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1;

   state_e             state_q, state_d;
   logic [ACC_W-1:0]   area_acc_q, area_acc_d;
   logic [ACC_W-1:0]   wsum_acc_q, wsum_acc_d;
   logic [CNT_W-1:0]   rule_cnt_q, rule_cnt_d;
   logic               neg_q, neg_d;
   logic [31:0]        crisp_out_q, crisp_out_d;
   logic               crisp_valid_q, crisp_valid_d;
   logic               div_by_zero_q, div_by_zero_d;
   logic               drop_err_q, drop_err_d;

   logic               beat;
   logic               last_beat;
   logic               area_pos;
   logic [ACC_W-1:0]   area_sx;
   logic [ACC_W-1:0]   wsum_sx;
   logic [ACC_W-1:0]   wsum_mag;
   logic               div_start;
   logic               div_done;
   logic [N_W-1:0]     div_quo;
   logic [31:0]        q_sat;

   assign in_ready    = (state_q == ACCUM);
   assign busy        = (state_q != ACCUM);
   assign crisp_out   = crisp_out_q;
   assign crisp_valid = crisp_valid_q;
   assign div_by_zero = div_by_zero_q;
   assign drop_err    = drop_err_q;

   assign beat      = in_valid & in_ready;
   assign last_beat = (rule_cnt_q == CNT_W'(NUM_RULES - 1));
   assign area_sx   = {{(ACC_W-32){area_in[31]}}, area_in};
   assign wsum_sx   = {{(ACC_W-32){wsum_in[31]}}, wsum_in};
   assign area_pos  = ~area_acc_q[ACC_W-1] & (area_acc_q != '0);

   // Magnitude as unsigned: the most negative sum maps to 2^(ACC_W-1).
   assign wsum_mag  = wsum_acc_q[ACC_W-1] ? (~wsum_acc_q + 1'b1)
                                          : wsum_acc_q;
   assign div_start = (state_q == LOAD) & area_pos;

   seq_udiv #(
      .N_W (N_W),
      .D_W (ACC_W)
   ) u_div (
      .clk   (clk),
      .rst   (rst),
      .start (div_start),
      .num   ({wsum_mag, {FRAC_BITS{1'b0}}}),
      .den   (area_acc_q),
      .done  (div_done),
      .quo   (div_quo)
   );

   assign q_sat = (|div_quo[N_W-1:31]) ? Q_MAX : div_quo[31:0];

   always_comb begin
      state_d       = state_q;
      area_acc_d    = area_acc_q;
      wsum_acc_d    = wsum_acc_q;
      rule_cnt_d    = rule_cnt_q;
      neg_d         = neg_q;
      crisp_out_d   = crisp_out_q;
      crisp_valid_d = 1'b0;
      div_by_zero_d = div_by_zero_q;
      drop_err_d    = drop_err_q | (in_valid & ~in_ready);
      unique case (state_q)
         ACCUM: begin
            if (beat) begin
               area_acc_d = area_acc_q + area_sx;
               wsum_acc_d = wsum_acc_q + wsum_sx;
               if (last_beat) begin
                  rule_cnt_d = '0;
                  state_d    = LOAD;
               end else begin
                  rule_cnt_d = rule_cnt_q + CNT_W'(1);
               end
            end
         end
         LOAD: begin
            if (!area_pos) begin
               crisp_out_d   = '0;
               div_by_zero_d = 1'b1;
               crisp_valid_d = 1'b1;
               area_acc_d    = '0;
               wsum_acc_d    = '0;
               state_d       = ACCUM;
            end else begin
               neg_d   = wsum_acc_q[ACC_W-1];
               state_d = DIV;
            end
         end
         DIV: begin
            if (div_done) begin
               crisp_out_d   = neg_q ? (~q_sat + 32'd1) : q_sat;
               div_by_zero_d = 1'b0;
               crisp_valid_d = 1'b1;
               area_acc_d    = '0;
               wsum_acc_d    = '0;
               state_d       = ACCUM;
            end
         end
         default: begin
            state_d = ACCUM;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= ACCUM;
         area_acc_q    <= '0;
         wsum_acc_q    <= '0;
         rule_cnt_q    <= '0;
         neg_q         <= 1'b0;
         crisp_out_q   <= '0;
         crisp_valid_q <= 1'b0;
         div_by_zero_q <= 1'b0;
         drop_err_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         area_acc_q    <= area_acc_d;
         wsum_acc_q    <= wsum_acc_d;
         rule_cnt_q    <= rule_cnt_d;
         neg_q         <= neg_d;
         crisp_out_q   <= crisp_out_d;
         crisp_valid_q <= crisp_valid_d;
         div_by_zero_q <= div_by_zero_d;
         drop_err_q    <= drop_err_d;
      end
   end

endmodule
